result_collector: RTL and testbench

RESULT_COLLECTOR -- requirements
Module: result_collector

---
 rtl/result_collector_pkg.sv | 17 +
 rtl/result_out_reg.sv | 65 ++++++
 rtl/result_collector.sv | 100 ++++++++++
 tb/tb_result_collector.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/result_collector_pkg.sv
// Shared definitions for the result collector: index codes, word widths and
// the collect FSM state encoding.
package result_collector_pkg;

  localparam int unsigned IDX_W  = 3;
  localparam int unsigned WORD_W = 4;
  localparam int unsigned RES_W  = 5;

  // Index value meaning "no bit this cycle".
  localparam logic [IDX_W-1:0] IDX_IDLE = 3'h7;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

endpackage

// File: rtl/result_out_reg.sv
// Output holding register for completed result words.
// Holds one word behind a valid/ready handshake, flags dropped words
// (sticky overflow) and optionally keeps the parity of the held word.
// Optional feature macro: RESULT_PARITY_EN (parity register; otherwise tied 0).
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   done        - a completed word is offered this cycle
//   word        - the completed word
//   rdy         - downstream ready
//   result      - held word
//   result_vld  - result holds an untaken word
//   overflow    - sticky: a completed word was dropped
//   parity      - XOR of the held word's bits (0 when parity is disabled)
module result_out_reg
  import result_collector_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             done,
  input  logic [RES_W-1:0] word,
  input  logic             rdy,
  output logic [RES_W-1:0] result,
  output logic             result_vld,
  output logic             overflow,
  output logic             parity
);

  logic load_c;

  // A new word fits when the holder is empty or is being emptied this edge.
  assign load_c = done && (!result_vld || rdy);

  // Holding register, valid flag and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result     <= '0;
      result_vld <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (load_c) begin
        result     <= word;
        result_vld <= 1'b1;
      end else if (result_vld && rdy) begin
        result_vld <= 1'b0;
      end
      if (done && result_vld && !rdy) begin
        overflow <= 1'b1;
      end
    end
  end

`ifdef RESULT_PARITY_EN
  // Parity tracks whichever word was last loaded into result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity <= 1'b0;
    end else if (load_c) begin
      parity <= ^word;
    end
  end
`else
  assign parity = 1'b0;
`endif

endmodule

// File: rtl/result_collector.sv
// Collects bit-serial result bits (weights 0..3) plus a final carry into a
// 5-bit word {carry, b3, b2, b1, b0} and hands it to an output register.
// Optional feature macro: RESULT_PARITY_EN (enables the PARITY register).
// Ports:
//   CLK, RST    - clock, asynchronous active-low reset
//   BIT_IN      - serial result bit
//   BIT_IDX     - bit weight 0..3, 7 = no bit, 4..6 illegal
//   CARRY_LAST  - final carry, used with index 3
//   RDY_IN      - downstream ready
//   RESULT      - assembled word
//   RESULT_VLD  - RESULT holds an untaken word
//   OVERFLOW    - sticky: a completed word was dropped
//   SEQ_ERR     - one-cycle pulse on an out-of-order index
//   PARITY      - parity of RESULT (0 when parity is disabled)
module result_collector
  import result_collector_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             BIT_IN,
  input  logic [IDX_W-1:0] BIT_IDX,
  input  logic             CARRY_LAST,
  input  logic             RDY_IN,
  output logic [RES_W-1:0] RESULT,
  output logic             RESULT_VLD,
  output logic             OVERFLOW,
  output logic             SEQ_ERR,
  output logic             PARITY
);

  state_t            state;
  logic [1:0]        exp_idx;
  logic [WORD_W-2:0] partial;

  logic              done_c;
  logic [RES_W-1:0]  word_c;

  // Word completes on the expected index 3; the output register loads it
  // at this same edge.
  always_comb begin
    done_c = 1'b0;
    word_c = {CARRY_LAST, BIT_IN, partial};
    if ((state == COLLECT) && (BIT_IDX == 3'd3) && (exp_idx == 2'd3)) begin
      done_c = 1'b1;
    end
  end

  // Collect FSM: index 7 is a bubble; anything out of order flags SEQ_ERR
  // and drops the partial word, with index 0 restarting immediately.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= IDLE;
      exp_idx <= 2'd0;
      partial <= '0;
      SEQ_ERR <= 1'b0;
    end else begin
      SEQ_ERR <= 1'b0;
      if (BIT_IDX != IDX_IDLE) begin
        if ((state == IDLE) && (BIT_IDX == 3'd0)) begin
          state   <= COLLECT;
          exp_idx <= 2'd1;
          partial <= (WORD_W-1)'(BIT_IN);
        end else if ((state == COLLECT) && (BIT_IDX == IDX_W'(exp_idx))) begin
          if (exp_idx == 2'd3) begin
            state   <= IDLE;
            exp_idx <= 2'd0;
            partial <= '0;
          end else begin
            partial[exp_idx] <= BIT_IN;
            exp_idx          <= 2'(exp_idx + 2'd1);
          end
        end else begin
          SEQ_ERR <= 1'b1;
          if (BIT_IDX == 3'd0) begin
            state   <= COLLECT;
            exp_idx <= 2'd1;
            partial <= (WORD_W-1)'(BIT_IN);
          end else begin
            state   <= IDLE;
            exp_idx <= 2'd0;
            partial <= '0;
          end
        end
      end
    end
  end

  result_out_reg u_out (
    .clk        (CLK),
    .rst_n      (RST),
    .done       (done_c),
    .word       (word_c),
    .rdy        (RDY_IN),
    .result     (RESULT),
    .result_vld (RESULT_VLD),
    .overflow   (OVERFLOW),
    .parity     (PARITY)
  );

endmodule

// File: tb/tb_result_collector.sv
// Directed testbench for result_collector with hand-computed expectations.
module tb_result_collector;
  import result_collector_pkg::*;

  logic             CLK;
  logic             RST;
  logic             BIT_IN;
  logic [IDX_W-1:0] BIT_IDX;
  logic             CARRY_LAST;
  logic             RDY_IN;
  logic [RES_W-1:0] RESULT;
  logic             RESULT_VLD;
  logic             OVERFLOW;
  logic             SEQ_ERR;
  logic             PARITY;

  int checks = 0;
  int errors = 0;

`ifdef RESULT_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  result_collector dut (
    .CLK        (CLK),
    .RST        (RST),
    .BIT_IN     (BIT_IN),
    .BIT_IDX    (BIT_IDX),
    .CARRY_LAST (CARRY_LAST),
    .RDY_IN     (RDY_IN),
    .RESULT     (RESULT),
    .RESULT_VLD (RESULT_VLD),
    .OVERFLOW   (OVERFLOW),
    .SEQ_ERR    (SEQ_ERR),
    .PARITY     (PARITY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic exp_par(input logic [4:0] w);
    return PAR_EN & (^w);
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [4:0] res, input logic vld,
                            input logic ovf, input logic err);
    check({tag, "_res"}, 8'(RESULT), 8'(res));
    check({tag, "_vld"}, 8'(RESULT_VLD), 8'(vld));
    check({tag, "_ovf"}, 8'(OVERFLOW), 8'(ovf));
    check({tag, "_err"}, 8'(SEQ_ERR), 8'(err));
    check({tag, "_par"}, 8'(PARITY), 8'(exp_par(res)));
  endtask

  // One index per clock; inputs change 1 time unit after the edge.
  task automatic drive(input logic [2:0] idx, input logic b, input logic c);
    BIT_IDX    = idx;
    BIT_IN     = b;
    CARRY_LAST = c;
    @(posedge CLK);
    #1;
    BIT_IDX    = IDX_IDLE;
    BIT_IN     = 1'b0;
    CARRY_LAST = 1'b0;
  endtask

  task automatic send_word(input logic [4:0] w);
    drive(3'd0, w[0], 1'b0);
    drive(3'd1, w[1], 1'b0);
    drive(3'd2, w[2], 1'b0);
    drive(3'd3, w[3], w[4]);
  endtask

  logic [2:0] bub_idx [7];
  logic       bub_bit [7];

  initial begin
    RST        = 1'b0;
    BIT_IN     = 1'b0;
    BIT_IDX    = IDX_IDLE;
    CARRY_LAST = 1'b0;
    RDY_IN     = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    expect_out("reset", 5'h00, 1'b0, 1'b0, 1'b0);
    RST = 1'b1;
    @(posedge CLK);
    #1;

    // Plain word 0x1D with ready high: valid for exactly one cycle.
    drive(3'd0, 1'b1, 1'b0);
    drive(3'd1, 1'b0, 1'b0);
    drive(3'd2, 1'b1, 1'b0);
    expect_out("t1_mid", 5'h00, 1'b0, 1'b0, 1'b0);
    drive(3'd3, 1'b1, 1'b1);
    expect_out("t1_word", 5'h1D, 1'b1, 1'b0, 1'b0);
    drive(IDX_IDLE, 1'b0, 1'b0);
    expect_out("t1_taken", 5'h1D, 1'b0, 1'b0, 1'b0);

    // Same word with bubbles between every bit.
    bub_idx = '{3'd0, 3'd7, 3'd1, 3'd7, 3'd2, 3'd7, 3'd3};
    bub_bit = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      drive(bub_idx[i], bub_bit[i], 1'b0);
      check("t2_bubble_err", 8'(SEQ_ERR), 8'h00);
      check("t2_bubble_vld", 8'(RESULT_VLD), 8'h00);
    end
    drive(bub_idx[6], bub_bit[6], 1'b1);
    expect_out("t2_word", 5'h1D, 1'b1, 1'b0, 1'b0);
    drive(IDX_IDLE, 1'b0, 1'b0);
    expect_out("t2_taken", 5'h1D, 1'b0, 1'b0, 1'b0);

    // Ready low, two back-to-back words: second is dropped.
    RDY_IN = 1'b0;
    send_word(5'h1D);
    expect_out("t3_first", 5'h1D, 1'b1, 1'b0, 1'b0);
    send_word(5'h03);
    expect_out("t3_drop", 5'h1D, 1'b1, 1'b1, 1'b0);
    drive(IDX_IDLE, 1'b0, 1'b0);
    expect_out("t3_hold", 5'h1D, 1'b1, 1'b1, 1'b0);
    RDY_IN = 1'b1;
    drive(IDX_IDLE, 1'b0, 1'b0);
    expect_out("t3_taken", 5'h1D, 1'b0, 1'b1, 1'b0);
    drive(IDX_IDLE, 1'b0, 1'b0);
    expect_out("t3_sticky", 5'h1D, 1'b0, 1'b1, 1'b0);

    // Completion in the same edge as a transfer loads the new word.
    RDY_IN = 1'b0;
    send_word(5'h1D);
    expect_out("t4_first", 5'h1D, 1'b1, 1'b1, 1'b0);
    drive(3'd0, 1'b1, 1'b0);
    drive(3'd1, 1'b1, 1'b0);
    drive(3'd2, 1'b1, 1'b0);
    RDY_IN = 1'b1;
    drive(3'd3, 1'b0, 1'b0);
    expect_out("t4_swap", 5'h07, 1'b1, 1'b1, 1'b0);
    drive(IDX_IDLE, 1'b0, 1'b0);
    expect_out("t4_taken", 5'h07, 1'b0, 1'b1, 1'b0);

    // Skipped index 2: error pulse on the idx-3 edge, no word.
    drive(3'd0, 1'b1, 1'b0);
    drive(3'd1, 1'b0, 1'b0);
    drive(3'd3, 1'b1, 1'b1);
    expect_out("t5_err", 5'h07, 1'b0, 1'b1, 1'b1);
    drive(IDX_IDLE, 1'b0, 1'b0);
    expect_out("t5_pulse", 5'h07, 1'b0, 1'b1, 1'b0);
    send_word(5'h1D);
    expect_out("t5_next", 5'h1D, 1'b1, 1'b1, 1'b0);
    drive(IDX_IDLE, 1'b0, 1'b0);

    // Index 0 mid-word restarts the word using the new bit 0.
    drive(3'd0, 1'b0, 1'b0);
    drive(3'd1, 1'b1, 1'b0);
    drive(3'd0, 1'b1, 1'b0);
    check("t6_restart_err", 8'(SEQ_ERR), 8'h01);
    drive(3'd1, 1'b0, 1'b0);
    check("t6_after_err", 8'(SEQ_ERR), 8'h00);
    drive(3'd2, 1'b1, 1'b0);
    drive(3'd3, 1'b1, 1'b1);
    expect_out("t6_word", 5'h1D, 1'b1, 1'b1, 1'b0);
    drive(IDX_IDLE, 1'b0, 1'b0);

    // Illegal index aborts; the following index 1 is out of order in IDLE.
    drive(3'd0, 1'b1, 1'b0);
    drive(3'd5, 1'b1, 1'b0);
    check("t6_illegal_err", 8'(SEQ_ERR), 8'h01);
    drive(3'd1, 1'b1, 1'b0);
    check("t6_idle_err", 8'(SEQ_ERR), 8'h01);
    drive(IDX_IDLE, 1'b0, 1'b0);

    // Reset with a held word and a partial word pending.
    RDY_IN = 1'b0;
    send_word(5'h03);
    expect_out("t7_held", 5'h03, 1'b1, 1'b1, 1'b0);
    drive(3'd0, 1'b1, 1'b0);
    drive(3'd1, 1'b0, 1'b0);
    RST = 1'b0;
    #2;
    expect_out("t7_rst", 5'h00, 1'b0, 1'b0, 1'b0);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    drive(3'd1, 1'b1, 1'b0);
    expect_out("t7_idx1", 5'h00, 1'b0, 1'b0, 1'b1);
    drive(3'd2, 1'b1, 1'b0);
    expect_out("t7_idx2", 5'h00, 1'b0, 1'b0, 1'b1);
    drive(3'd3, 1'b1, 1'b1);
    expect_out("t7_idx3", 5'h00, 1'b0, 1'b0, 1'b1);
    drive(IDX_IDLE, 1'b0, 1'b0);
    expect_out("t7_end", 5'h00, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
